unit_pipe: RTL and testbench
============================

Name: unit_pipe

Overview:
- Parametrised successor to the single-layer fabric unit.
- WIDTH-bit datapath through LAYERS cascaded LUT2 layers, then an output invert mask.
- Configuration arrives as a byte stream with a valid/ready handshake. It fills a shadow register and is committed atomically, so the datapath never sees a half-loaded config.
- Optional per-layer pipelining; sits between tile input mux and tile output register.

Parameters:
- WIDTH, 8, datapath width; must be >= 2.
- LAYERS, 2, number of cascaded LUT2 layers; must be >= 1.
- PIPE, 0, 0 = combinational layers; 1 = register after every layer.
- Derived: CFG_BITS = WIDTH + LAYERS*WIDTH*4; NBYTES = ceil(CFG_BITS/8).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset.
- data_in  in  WIDTH  datapath input.
- data_out  out  WIDTH  registered datapath result.
- cfg_data  in  8  config command/payload byte.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  unit can accept a byte; a transfer occurs when cfg_valid && cfg_ready.
- cfg_busy  out  1  load in progress (state != IDLE).
- cfg_err  out  1  sticky: last load aborted.

Behaviour:
- Interface decided: one clock; reset is synchronous and active-high.
- Reset (rst=1 at clk edge):
  - data_out=0, cfg_err=0, cfg_busy=0, cfg_ready=1, state=IDLE.
  - Shadow and active config = passthrough: mask all 0, every LUT = 4'b1010.
  - Pipeline registers = 0.
  - Applies from any state, including mid-load; a partial load is discarded.
- Config layout (shadow and active identical):
  - bits [WIDTH-1:0] = output invert mask.
  - LUT for layer l, bit i at WIDTH + (l*WIDTH+i)*4, 4 bits.
- Layer function:
  - x0 = data_in.
  - x(l+1)[i] = LUT_l,i[{x_l[(i+1) mod WIDTH], x_l[i]}] (index bit1 = neighbour, bit0 = self).
  - res = x_LAYERS ^ mask.
- Latency:
  - PIPE=0: data_out <= res every cycle; latency 1.
  - PIPE=1: each layer output registered, then data_out register; latency LAYERS+1. Registers update every cycle (no stall).
- Loader FSM, one transfer per cycle max:
  - IDLE: byte 0xA5 -> LOAD, byte count=0, cfg_err cleared. Any other byte is accepted and ignored.
  - LOAD: each transfer writes shadow[8k+7:8k] (k = count), then count++. Bits above CFG_BITS-1 in the final byte are dropped. Transfer with count==NBYTES-1 -> ARM. Cycles without transfer hold state.
  - ARM, byte 0x5A: active <= shadow at that edge -> COMMIT.
  - ARM, any other byte: cfg_err=1 -> IDLE; active unchanged; shadow keeps its partial contents but is never used unless reloaded.
  - COMMIT: cfg_ready=0 for exactly one cycle -> IDLE.
- cfg_ready is 1 in all states except COMMIT.
- cfg_busy=1 in LOAD, ARM, COMMIT.
- Commit timing:
  - data_in sampled on the edge after the 0x5A transfer edge uses the new config.
  - PIPE=1: data already in flight passes the remaining layers and the mask with the new config. This mixing is defined behaviour; the bench checks it.
- A 0xA5 byte during LOAD is payload, not a restart.
- Simultaneous rst and cfg transfer: rst wins.

Test Plan:
1. Passthrough after reset (W=8, L=2, PIPE=0): data_in=0x3C -> data_out=0x3C one cycle later; cfg_busy=0, cfg_err=0.
2. Invert load:
   - Stimulus: 0xA5, 0xFF, 0xAA x8, 0x5A.
   - cfg_busy high from the cycle after 0xA5 until after COMMIT.
   - cfg_ready low exactly one cycle after 0x5A.
   - Then data_in=0x3C -> data_out=0xC3.
3. AND layer:
   - Stimulus: 0xA5, 0x00, 0x88 x4, 0xAA x4, 0x5A.
   - data_in=0xFF -> 0xFF.
   - data_in=0x0F -> 0x07 (bit3 = d3&d4 = 0; bit7 = d7&d0 = 0).
4. Abort:
   - Stimulus: 0xA5, 0xFF, 0xAA x8, 0x00.
   - cfg_err=1; data_in=0x3C still -> 0x3C.
   - Next 0xA5 clears cfg_err.
5. Handshake and reset mid-load:
   - Hold cfg_valid low for 3 cycles mid-LOAD; count must not advance.
   - Assert rst after 4 payload bytes -> IDLE, cfg_busy=0, config is passthrough.
   - A full load afterwards succeeds.
6. PIPE=1, L=2:
   - Single-cycle data_in=0x01 among 0x00 -> data_out=0x01 exactly 3 cycles later.
   - Commit the mask 0xFF while the impulse is in flight -> impulse emerges as 0xFE.

Source files
------------

// File: rtl/unit_pipe.sv
// unit_pipe: WIDTH-bit datapath through LAYERS cascaded LUT2 layers and an
// output invert mask. Configuration arrives as a byte stream over a
// valid/ready handshake. It fills a shadow register and is committed to the
// active register in one edge, so the datapath never sees a half-loaded set.
module unit_pipe #(
   parameter int WIDTH  = 8,
   parameter int LAYERS = 2,
   parameter int PIPE   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   input  logic [7:0]       cfg_data,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             cfg_busy,
   output logic             cfg_err
);

   localparam int CFG_BITS = WIDTH + LAYERS * WIDTH * 4;
   localparam int NBYTES   = (CFG_BITS + 7) / 8;
   localparam int CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

   // Passthrough config: mask clear, every LUT copies its own input bit.
   function automatic logic [CFG_BITS-1:0] pass_cfg();
      logic [CFG_BITS-1:0] c;
      c = '0;
      for (int k = 0; k < LAYERS * WIDTH; k++) begin
         c[WIDTH + k*4 +: 4] = 4'b1010;
      end
      return c;
   endfunction

   localparam logic [CFG_BITS-1:0] PASS_CFG = pass_cfg();

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ARM,
      COMMIT
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [CNT_W-1:0]    byte_cnt;
   logic [CFG_BITS-1:0] shadow_cfg;
   logic [CFG_BITS-1:0] active_cfg;
   logic                xfer;
   logic                start_load;
   logic                write_byte;
   logic                do_commit;
   logic                do_abort;

   // The one-cycle COMMIT gap is the only time a byte cannot be accepted.
   assign cfg_ready = (state != COMMIT);
   assign xfer      = cfg_valid && cfg_ready;

   // Loader next-state and control strobes.
   always_comb begin
      state_next = state;
      cfg_busy   = 1'b1;
      start_load = 1'b0;
      write_byte = 1'b0;
      do_commit  = 1'b0;
      do_abort   = 1'b0;
      case (state)
         IDLE: begin
            cfg_busy = 1'b0;
            if (xfer && cfg_data == 8'hA5) begin
               start_load = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (xfer) begin
               write_byte = 1'b1;
               if (byte_cnt == LAST_BYTE) begin
                  state_next = ARM;
               end
            end
         end
         ARM: begin
            if (xfer) begin
               if (cfg_data == 8'h5A) begin
                  do_commit  = 1'b1;
                  state_next = COMMIT;
               end else begin
                  do_abort   = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         COMMIT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Loader state register; reset abandons any load in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Shadow fill, atomic commit into the active config, and the sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt   <= '0;
         shadow_cfg <= PASS_CFG;
         active_cfg <= PASS_CFG;
         cfg_err    <= 1'b0;
      end else begin
         if (start_load) begin
            byte_cnt <= '0;
            cfg_err  <= 1'b0;
         end
         if (write_byte) begin
            for (int p = 0; p < CFG_BITS; p++) begin
               if (p / 8 == int'(byte_cnt)) begin
                  shadow_cfg[p] <= cfg_data[p % 8];
               end
            end
            byte_cnt <= byte_cnt + CNT_W'(1);
         end
         if (do_commit) begin
            active_cfg <= shadow_cfg;
         end
         if (do_abort) begin
            cfg_err <= 1'b1;
         end
      end
   end

   for (genvar l = 0; l < LAYERS; l++) begin : g_layer
      logic [WIDTH-1:0] layer_in;
      logic [WIDTH-1:0] lut_out;
      logic [WIDTH-1:0] layer_out;
      logic [3:0]       lut_nib;

      if (l == 0) begin : g_first
         assign layer_in = data_in;
      end else begin : g_next
         assign layer_in = g_layer[l-1].layer_out;
      end

      // Each bit looks up its LUT with {neighbour, self} as the index.
      always_comb begin
         lut_out = '0;
         lut_nib = '0;
         for (int i = 0; i < WIDTH; i++) begin
            lut_nib    = active_cfg[WIDTH + (l*WIDTH + i)*4 +: 4];
            lut_out[i] = lut_nib[{layer_in[(i+1) % WIDTH], layer_in[i]}];
         end
      end

      if (PIPE != 0) begin : g_pipe
         // Layer output register; runs every cycle with no stall.
         always_ff @(posedge clk) begin
            if (rst) begin
               layer_out <= '0;
            end else begin
               layer_out <= lut_out;
            end
         end
      end else begin : g_comb
         assign layer_out = lut_out;
      end
   end

   // Final mask and output register, using whichever config is active now.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
      end else begin
         data_out <= g_layer[LAYERS-1].layer_out ^ active_cfg[WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_unit_pipe.sv
// Testbench for unit_pipe: one combinational and one pipelined instance fed
// the same stimulus, compared every cycle against a byte-level model, plus
// hand-computed checks that pin down the model itself.
module tb_unit_pipe;

   localparam int W  = 8;
   localparam int L  = 2;
   localparam int CB = W + L * W * 4;
   localparam int NB = (CB + 7) / 8;

   localparam int MI = 0;
   localparam int ML = 1;
   localparam int MA = 2;
   localparam int MC = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] data_in;
   logic [7:0]   cfg_data;
   logic         cfg_valid;
   logic [W-1:0] data_out0, data_out1;
   logic         ready0, busy0, err0;
   logic         ready1, busy1, err1;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   bit rand_data = 1'b0;

   logic [CB-1:0] m_active;
   logic [7:0]    m_shadow [NB];
   int            m_mode;
   int            m_cnt;
   logic          m_err;
   logic [W-1:0]  m_out0, m_out1;
   logic [W-1:0]  m_stage [L];

   unit_pipe #(.WIDTH(W), .LAYERS(L), .PIPE(0)) dut0 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out0),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready0),
      .cfg_busy(busy0), .cfg_err(err0)
   );

   unit_pipe #(.WIDTH(W), .LAYERS(L), .PIPE(1)) dut1 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out1),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready1),
      .cfg_busy(busy1), .cfg_err(err1)
   );

   always #5 clk = ~clk;

   function automatic logic [CB-1:0] pass_cfg();
      logic [CB-1:0] c;
      c = '0;
      for (int k = 0; k < L * W; k++) c[W + k*4 +: 4] = 4'b1010;
      return c;
   endfunction

   function automatic logic [W-1:0] layer_eval(input logic [CB-1:0] cfg, input int l, input logic [W-1:0] x);
      logic [W-1:0] y;
      logic [3:0]   nib;
      int           sel;
      y = '0;
      for (int i = 0; i < W; i++) begin
         nib  = cfg[W + (l*W + i)*4 +: 4];
         sel  = 2 * int'(x[(i+1) % W]) + int'(x[i]);
         y[i] = nib[sel];
      end
      return y;
   endfunction

   // Reference model, advanced on every rising edge from pre-edge values.
   always @(posedge clk) begin
      logic [W-1:0]  x;
      logic [CB-1:0] cfg_now;
      logic [CB-1:0] packed_cfg;
      bit            xfer;
      if (rst) begin
         m_active = pass_cfg();
         packed_cfg = pass_cfg();
         for (int k = 0; k < NB; k++)
            for (int j = 0; j < 8; j++)
               m_shadow[k][j] = (8*k + j < CB) ? packed_cfg[8*k + j] : 1'b0;
         m_mode = MI;
         m_cnt  = 0;
         m_err  = 1'b0;
         m_out0 = '0;
         m_out1 = '0;
         for (int l = 0; l < L; l++) m_stage[l] = '0;
      end else begin
         cfg_now = m_active;
         x = data_in;
         for (int l = 0; l < L; l++) x = layer_eval(cfg_now, l, x);
         m_out0 = x ^ cfg_now[W-1:0];
         m_out1 = m_stage[L-1] ^ cfg_now[W-1:0];
         for (int l = L - 1; l > 0; l--) m_stage[l] = layer_eval(cfg_now, l, m_stage[l-1]);
         m_stage[0] = layer_eval(cfg_now, 0, data_in);
         xfer = cfg_valid && (m_mode != MC);
         if (m_mode == MC) begin
            m_mode = MI;
         end else if (xfer) begin
            case (m_mode)
               MI: if (cfg_data == 8'hA5) begin m_mode = ML; m_cnt = 0; m_err = 1'b0; end
               ML: begin
                  m_shadow[m_cnt] = cfg_data;
                  m_cnt++;
                  if (m_cnt == NB) m_mode = MA;
               end
               MA: begin
                  if (cfg_data == 8'h5A) begin
                     for (int b = 0; b < CB; b++) m_active[b] = m_shadow[b/8][b%8];
                     m_mode = MC;
                  end else begin
                     m_err  = 1'b1;
                     m_mode = MI;
                  end
               end
               default: m_mode = MI;
            endcase
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check_output("data_out pipe0", 32'(data_out0), 32'(m_out0));
         check_output("data_out pipe1", 32'(data_out1), 32'(m_out1));
         check_output("cfg_ready", 32'(ready0), 32'(m_mode != MC));
         check_output("cfg_busy", 32'(busy0), 32'(m_mode != MI));
         check_output("cfg_err", 32'(err0), 32'(m_err));
         check_output("cfg_ready pipe1", 32'(ready1), 32'(m_mode != MC));
         check_output("cfg_busy pipe1", 32'(busy1), 32'(m_mode != MI));
         check_output("cfg_err pipe1", 32'(err1), 32'(m_err));
      end
   end

   task automatic step();
      @(negedge clk);
      if (rand_data) data_in = W'($urandom);
   endtask

   // Present a byte; it transfers on the next rising edge with ready high.
   task automatic send_byte(input logic [7:0] b);
      int guard;
      step();
      cfg_valid = 1'b1;
      cfg_data  = b;
      guard = 0;
      while (!ready0 && guard < 20) begin
         step();
         guard++;
      end
      if (guard >= 20) check_output("cfg_ready timeout", 32'(ready0), 32'd1);
   endtask

   task automatic cfg_release();
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      cfg_valid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic apply_stimulus_load(input logic [7:0] mask, input logic [7:0] lut0, input logic [7:0] lut1, input logic [7:0] last);
      send_byte(8'hA5);
      send_byte(mask);
      for (int k = 0; k < 4; k++) send_byte(lut0);
      for (int k = 0; k < 4; k++) send_byte(lut1);
      send_byte(last);
      cfg_release();
      step();
   endtask

   task automatic random_load();
      send_byte(8'($urandom));
      send_byte(8'hA5);
      for (int k = 0; k < NB; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            cfg_release();
            repeat ($urandom_range(0, 2)) step();
         end
         send_byte(8'($urandom));
         if ($urandom_range(0, 29) == 0) begin
            step();
            rst = 1'b1;
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data = 8'hA5;
            step();
            rst = 1'b0;
            cfg_valid = 1'b0;
            return;
         end
      end
      send_byte(($urandom_range(0, 3) != 0) ? 8'h5A : 8'($urandom));
      cfg_release();
      step();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      cfg_valid = 1'b0;
      cfg_data = 8'h00;
      data_in = '0;
      step();
      step();
      rst = 1'b0;
      chk_en = 1'b1;

      // Passthrough after reset.
      data_in = 8'h3C;
      step();
      check_output("reset passthrough", 32'(data_out0), 32'h3C);
      check_output("reset busy", 32'(busy0), 32'd0);
      check_output("reset err", 32'(err0), 32'd0);

      // Invert load with commit handshake.
      send_byte(8'hA5);
      send_byte(8'hFF);
      check_output("busy after A5", 32'(busy0), 32'd1);
      for (int k = 0; k < 8; k++) send_byte(8'hAA);
      send_byte(8'h5A);
      cfg_release();
      check_output("commit ready low", 32'(ready0), 32'd0);
      check_output("commit busy", 32'(busy0), 32'd1);
      step();
      check_output("ready after commit", 32'(ready0), 32'd1);
      check_output("idle after commit", 32'(busy0), 32'd0);
      data_in = 8'h3C;
      step();
      check_output("invert mask", 32'(data_out0), 32'hC3);

      // AND layer.
      apply_stimulus_load(8'h00, 8'h88, 8'hAA, 8'h5A);
      data_in = 8'hFF;
      step();
      check_output("and all ones", 32'(data_out0), 32'hFF);
      data_in = 8'h0F;
      step();
      check_output("and 0x0F", 32'(data_out0), 32'h07);

      // Abort leaves the active config untouched; next A5 clears the error.
      do_reset();
      apply_stimulus_load(8'hFF, 8'hAA, 8'hAA, 8'h00);
      check_output("abort err", 32'(err0), 32'd1);
      data_in = 8'h3C;
      step();
      check_output("abort passthrough", 32'(data_out0), 32'h3C);
      send_byte(8'hA5);
      cfg_release();
      check_output("err cleared", 32'(err0), 32'd0);
      for (int k = 0; k < 9; k++) send_byte(8'hAA);
      send_byte(8'h5A);
      cfg_release();
      step();

      // Handshake gaps mid-load must not advance the byte count.
      send_byte(8'hA5);
      send_byte(8'hFF);
      send_byte(8'hAA);
      send_byte(8'hAA);
      cfg_release();
      step();
      step();
      for (int k = 0; k < 6; k++) send_byte(8'hAA);
      send_byte(8'h5A);
      cfg_release();
      step();
      data_in = 8'h3C;
      step();
      check_output("load with gaps", 32'(data_out0), 32'hC3);

      // Reset mid-load, coinciding with a byte transfer.
      send_byte(8'hA5);
      for (int k = 0; k < 4; k++) send_byte(8'h00);
      step();
      rst = 1'b1;
      cfg_data = 8'h00;
      step();
      rst = 1'b0;
      cfg_valid = 1'b0;
      check_output("busy after rst", 32'(busy0), 32'd0);
      data_in = 8'h3C;
      step();
      check_output("rst passthrough", 32'(data_out0), 32'h3C);
      apply_stimulus_load(8'h00, 8'h88, 8'hAA, 8'h5A);
      data_in = 8'h0F;
      step();
      check_output("load after rst", 32'(data_out0), 32'h07);

      // Pipelined impulse latency.
      do_reset();
      data_in = 8'h00;
      step();
      data_in = 8'h01;
      step();
      data_in = 8'h00;
      check_output("pipe impulse c1", 32'(data_out1), 32'h00);
      step();
      check_output("pipe impulse c2", 32'(data_out1), 32'h00);
      step();
      check_output("pipe impulse c3", 32'(data_out1), 32'h01);
      step();
      check_output("pipe impulse c4", 32'(data_out1), 32'h00);

      // Commit the mask while an impulse is in flight.
      send_byte(8'hA5);
      send_byte(8'hFF);
      for (int k = 0; k < 8; k++) send_byte(8'hAA);
      step();
      cfg_valid = 1'b0;
      data_in = 8'h01;
      step();
      data_in = 8'h00;
      cfg_valid = 1'b1;
      cfg_data = 8'h5A;
      check_output("pipe0 before commit", 32'(data_out0), 32'h01);
      step();
      cfg_valid = 1'b0;
      step();
      check_output("in-flight impulse", 32'(data_out1), 32'hFE);
      step();
      check_output("after impulse", 32'(data_out1), 32'hFF);

      // Randomized loads, aborts, resets and data against the model.
      rand_data = 1'b1;
      for (int n = 0; n < 60; n++) random_load();
      rand_data = 1'b0;
      do_reset();
      step();
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
